// File: rtl/pr_pkg.sv
// Shared definitions for the PR vertex buffer: mode encodings, default widths,
// and the drain controller state type.
package pr_pkg;

  localparam int PR_DATA_W  = 32;
  localparam int PR_ADDR_W  = 10;
  localparam int PR_HAZ_WIN = 7;

  typedef enum logic [1:0] {
    PR_MODE_IDLE    = 2'd0,
    PR_MODE_SCATTER = 2'd1,
    PR_MODE_GATHER  = 2'd2,
    PR_MODE_DRAIN   = 2'd3
  } pr_mode_e;

  typedef enum logic [1:0] {
    DR_ISSUE = 2'd0,
    DR_LOAD  = 2'd1,
    DR_HOLD  = 2'd2,
    DR_END   = 2'd3
  } pr_drain_state_e;

endpackage

// File: rtl/pr_hazard_scoreboard.sv
// Read-after-write hazard window for gather: remembers recently accepted read
// addresses until their write-back arrives or they age out.
module pr_hazard_scoreboard
  import pr_pkg::*;
#(
  parameter int ADDR_W  = PR_ADDR_W,
  parameter int HAZ_WIN = PR_HAZ_WIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              hit
);

  logic [ADDR_W-1:0]  addr_reg [HAZ_WIN];
  logic [HAZ_WIN-1:0] valid_reg;
  logic [HAZ_WIN-1:0] match_q;
  logic [HAZ_WIN-1:0] match_wb;
  logic [HAZ_WIN-1:0] kill;
  logic               found;

  genvar gi;
  generate
    for (gi = 0; gi < HAZ_WIN; gi++) begin : g_cmp
      assign match_q[gi]  = valid_reg[gi] && (addr_reg[gi] == query_addr);
      assign match_wb[gi] = valid_reg[gi] && wb_valid && (addr_reg[gi] == wb_addr);
    end
  endgenerate

  assign hit = |match_q;

  // A write-back retires only the oldest outstanding read of its address.
  always_comb begin
    kill  = '0;
    found = 1'b0;
    for (int i = HAZ_WIN - 1; i >= 0; i--) begin
      if (match_wb[i] && !found) begin
        kill[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg[0] <= push_valid;
      for (int i = 1; i < HAZ_WIN; i++) begin
        valid_reg[i] <= !clr && valid_reg[i-1] && !kill[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_reg[0] <= push_addr;
    for (int i = 1; i < HAZ_WIN; i++) begin
      addr_reg[i] <= addr_reg[i-1];
    end
  end

endmodule

// File: rtl/pr_vertex_buffer.sv
// Partition-local vertex attribute store: init load, scatter/gather reads with
// gather hazard protection and write-back, and a backpressured drain stream.
module pr_vertex_buffer
  import pr_pkg::*;
#(
  parameter int DATA_W  = PR_DATA_W,
  parameter int ADDR_W  = PR_ADDR_W,
  parameter int HAZ_WIN = PR_HAZ_WIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] init_data,
  input  logic              init_valid,
  output logic              init_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_valid,
  output logic [DATA_W-1:0] drain_data,
  output logic [ADDR_W-1:0] drain_addr,
  output logic              drain_valid,
  input  logic              drain_ready,
  output logic              done
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

  pr_mode_e mode_e, mode_q;
  logic     mode_chg;

  assign mode_e   = pr_mode_e'(mode);
  assign mode_chg = (mode_e != mode_q);

  always_ff @(posedge clk) begin
    if (rst) mode_q <= PR_MODE_IDLE;
    else     mode_q <= mode_e;
  end

  // Load path
  logic [ADDR_W-1:0] load_cnt_reg;
  logic              init_ready_reg;
  logic              load_we, load_last;

  assign load_we    = (mode_e == PR_MODE_IDLE) && !mode_chg && init_valid && init_ready_reg;
  assign load_last  = load_we && (load_cnt_reg == LAST_ADDR);
  assign init_ready = init_ready_reg;

  always_ff @(posedge clk) begin
    if (rst || mode_chg) begin
      load_cnt_reg   <= '0;
      init_ready_reg <= 1'b1;
    end else if (load_we) begin
      if (load_last) init_ready_reg <= 1'b0;
      else           load_cnt_reg   <= load_cnt_reg + ADDR_ONE;
    end
  end

  // Read / write-back path
  logic              gather, haz_hit, rd_accept, gather_we;
  logic              rd_valid_reg, byp_reg;
  logic [DATA_W-1:0] byp_data_reg;

  assign gather    = (mode_e == PR_MODE_GATHER);
  assign rd_ready  = (mode_e == PR_MODE_SCATTER) || (gather && !haz_hit);
  assign rd_accept = rd_valid && rd_ready;
  assign gather_we = gather && wr_valid;

  pr_hazard_scoreboard #(
    .ADDR_W  (ADDR_W),
    .HAZ_WIN (HAZ_WIN)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .clr        (mode_chg),
    .push_addr  (rd_addr),
    .push_valid (rd_accept && gather),
    .wb_addr    (wr_addr),
    .wb_valid   (gather_we),
    .query_addr (rd_addr),
    .hit        (haz_hit)
  );

  // Drain controller state
  pr_drain_state_e   dr_state_reg, dr_state_next;
  logic [ADDR_W-1:0] drain_cnt_reg, drain_addr_reg;
  logic [DATA_W-1:0] drain_data_reg;
  logic              drain_active, dr_load, dr_hs;

  assign drain_active = (mode_e == PR_MODE_DRAIN) && !mode_chg;

  // Single simple-dual-port array; the read port is shared by reads and drain
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata;

  assign mem_we    = load_we || gather_we;
  assign mem_waddr = load_we ? load_cnt_reg : wr_addr;
  assign mem_wdata = load_we ? init_data : wr_data;
  assign mem_raddr = (mode_e == PR_MODE_DRAIN) ? drain_cnt_reg : rd_addr;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_q <= mem[mem_raddr];
  end

  // The array read returns old data on a same-address write, so forward it
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      byp_reg      <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      rd_valid_reg <= rd_accept;
      byp_reg      <= rd_accept && gather_we && (wr_addr == rd_addr);
      byp_data_reg <= wr_data;
    end
  end

  assign rd_data_valid = rd_valid_reg;
  assign rd_data       = rd_valid_reg ? (byp_reg ? byp_data_reg : mem_q) : '0;

  always_comb begin
    dr_state_next = dr_state_reg;
    dr_load       = 1'b0;
    dr_hs         = 1'b0;
    if (!drain_active) begin
      dr_state_next = DR_ISSUE;
    end else begin
      case (dr_state_reg)
        DR_ISSUE: dr_state_next = DR_LOAD;
        DR_LOAD: begin
          dr_load       = 1'b1;
          dr_state_next = DR_HOLD;
        end
        DR_HOLD: begin
          if (drain_ready) begin
            dr_hs         = 1'b1;
            dr_state_next = (drain_cnt_reg == LAST_ADDR) ? DR_END : DR_ISSUE;
          end
        end
        default: dr_state_next = DR_END;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dr_state_reg <= DR_ISSUE;
    else     dr_state_reg <= dr_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || !drain_active) begin
      drain_cnt_reg <= '0;
    end else if (dr_hs && (drain_cnt_reg != LAST_ADDR)) begin
      drain_cnt_reg <= drain_cnt_reg + ADDR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_data_reg <= '0;
      drain_addr_reg <= '0;
    end else if (dr_load) begin
      drain_data_reg <= mem_q;
      drain_addr_reg <= drain_cnt_reg;
    end
  end

  assign drain_valid = (dr_state_reg == DR_HOLD);
  assign drain_data  = drain_data_reg;
  assign drain_addr  = drain_addr_reg;

  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= load_last || (dr_hs && (drain_cnt_reg == LAST_ADDR));
  end

endmodule

// File: tb/tb_pr_vertex_buffer.sv
// Directed bench for pr_vertex_buffer: read results go through a queue-based
// scoreboard; load, hazard, bypass, drain and reset behaviour checked inline.
module tb_pr_vertex_buffer;
  import pr_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] init_data = '0;
  logic          init_valid = 1'b0;
  logic          init_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] drain_data;
  logic [AW-1:0] drain_addr;
  logic          drain_valid;
  logic          drain_ready = 1'b0;
  logic          done;

  always #5 clk = ~clk;

  pr_vertex_buffer #(.DATA_W(DW), .ADDR_W(AW), .HAZ_WIN(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .init_data     (init_data),
    .init_valid    (init_valid),
    .init_ready    (init_ready),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .wr_data       (wr_data),
    .wr_addr       (wr_addr),
    .wr_valid      (wr_valid),
    .drain_data    (drain_data),
    .drain_addr    (drain_addr),
    .drain_valid   (drain_valid),
    .drain_ready   (drain_ready),
    .done          (done)
  );

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic          acc_pending = 1'b0;
  logic [DW-1:0] model [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; read data must appear exactly one cycle after an accepted request
  task automatic cyc();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    chk("rd_data_valid", 32'(rd_data_valid), 32'(acc_pending));
    if (acc_pending) begin
      e = exp_q.pop_front();
      chk("rd_data", rd_data, e);
    end
    acc_pending = 1'b0;
  endtask

  task automatic rd_req(input logic [AW-1:0] a, input logic exp_rdy, input logic [DW-1:0] exp_d,
                        input string tag);
    rd_addr  = a;
    rd_valid = 1'b1;
    #1;
    chk(tag, 32'(rd_ready), 32'(exp_rdy));
    if (exp_rdy) begin
      exp_q.push_back(exp_d);
      acc_pending = 1'b1;
    end
    cyc();
    rd_valid = 1'b0;
  endtask

  initial begin
    int            early;
    int            next_exp;
    logic          hold_prev, hs_final, finished, found;
    logic [DW-1:0] held_d;
    logic [AW-1:0] held_a, seen_a;

    repeat (2) cyc();
    chk("rst_init_ready", 32'(init_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_drain_valid", 32'(drain_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_drain_data", drain_data, 32'd0);
    rst = 1'b0;
    cyc();
    rd_req(10'd0, 1'b0, '0, "idle_rd_ready");

    early = 0;
    for (int a = 0; a < DEPTH; a++) begin
      init_data  = 32'(a * 3);
      init_valid = 1'b1;
      model[a]   = 32'(a * 3);
      cyc();
      if (a < DEPTH - 1 && done) early++;
    end
    init_valid = 1'b0;
    chk("load_early_done", 32'(early), 32'd0);
    chk("load_done", 32'(done), 32'd1);
    chk("load_init_ready", 32'(init_ready), 32'd0);
    cyc();
    chk("load_done_pulse", 32'(done), 32'd0);
    init_data  = 32'hDEAD;
    init_valid = 1'b1;
    cyc();
    init_valid = 1'b0;

    mode = PR_MODE_SCATTER;
    cyc();
    rd_req(10'd5, 1'b1, 32'd15, "sc_rd5_ready");
    rd_req(10'd5, 1'b1, 32'd15, "sc_rd5_again_ready");
    wr_valid = 1'b1; wr_addr = 10'd3; wr_data = 32'hFF;
    cyc();
    wr_valid = 1'b0;
    rd_req(10'd3, 1'b1, 32'd9, "sc_rd3_ready");

    mode = PR_MODE_GATHER;
    cyc();
    rd_req(10'd7, 1'b1, 32'd21, "g_rd7_ready");
    rd_req(10'd7, 1'b0, '0, "g_rd7_stall1");
    rd_req(10'd7, 1'b0, '0, "g_rd7_stall2");
    wr_valid = 1'b1; wr_addr = 10'd7; wr_data = 32'h1234; model[7] = 32'h1234;
    rd_req(10'd7, 1'b0, '0, "g_rd7_stall_wb");
    wr_valid = 1'b0;
    rd_req(10'd7, 1'b1, 32'h1234, "g_rd7_after_wb");

    rd_req(10'd20, 1'b1, 32'd60, "g_rd20_ready");
    for (int k = 0; k < 7; k++) rd_req(10'd20, 1'b0, '0, "g_rd20_stall");
    rd_req(10'd20, 1'b1, 32'd60, "g_rd20_aged_out");

    wr_valid = 1'b1; wr_addr = 10'd9; wr_data = 32'h55; model[9] = 32'h55;
    rd_req(10'd9, 1'b1, 32'h55, "g_bypass9_ready");
    wr_data = 32'h66; model[9] = 32'h66;
    rd_req(10'd10, 1'b1, 32'd30, "g_rd10_nostall");
    wr_valid = 1'b0;
    rd_req(10'd9, 1'b1, 32'h66, "g_rd9_after_clear");

    mode = PR_MODE_DRAIN;
    rd_req(10'd0, 1'b0, '0, "drain_rd_ready");
    next_exp  = 0;
    hold_prev = 1'b0;
    finished  = 1'b0;
    held_d    = '0;
    held_a    = '0;
    for (int c = 0; c < 8000 && !finished; c++) begin
      drain_ready = (c % 4 == 0) || (c % 4 == 3);
      hs_final    = 1'b0;
      #1;
      if (hold_prev) begin
        chk("drain_valid_held", 32'(drain_valid), 32'd1);
        chk("drain_data_stable", drain_data, held_d);
        chk("drain_addr_stable", 32'(drain_addr), 32'(held_a));
      end
      hold_prev = 1'b0;
      if (drain_valid) begin
        if (drain_ready) begin
          chk("drain_addr", 32'(drain_addr), 32'(next_exp));
          chk("drain_data", drain_data, model[next_exp % DEPTH]);
          hs_final = (next_exp == DEPTH - 1);
          next_exp++;
        end else begin
          hold_prev = 1'b1;
          held_d    = drain_data;
          held_a    = drain_addr;
        end
      end
      cyc();
      chk("drain_done", 32'(done), 32'(hs_final));
      if (hs_final) finished = 1'b1;
    end
    chk("drain_count", 32'(next_exp), 32'(DEPTH));
    drain_ready = 1'b1;
    cyc();
    chk("drain_after_valid", 32'(drain_valid), 32'd0);
    chk("drain_after_done", 32'(done), 32'd0);

    mode = PR_MODE_IDLE;
    cyc();
    mode  = PR_MODE_DRAIN;
    found = 1'b0;
    seen_a = '0;
    for (int c = 0; c < 1000 && !found; c++) begin
      #1;
      if (drain_valid && drain_addr == 10'd100) begin
        found  = 1'b1;
        seen_a = drain_addr;
      end else begin
        cyc();
      end
    end
    chk("rst_mid_reached", 32'(seen_a), 32'd100);
    drain_ready = 1'b0;
    rst = 1'b1;
    cyc();
    chk("rst_mid_drain_valid", 32'(drain_valid), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_init_ready", 32'(init_ready), 32'd1);
    rst = 1'b0;
    drain_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      #1;
      if (drain_valid) begin
        found = 1'b1;
        chk("restart_addr", 32'(drain_addr), 32'd0);
        chk("restart_data", drain_data, model[0]);
      end else begin
        cyc();
      end
    end
    chk("restart_seen", 32'(found), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
